// File: rtl/bambu_extmem_slave_if.sv
// bambu_extmem_slave_if: two-channel master bus between the accelerator and the external byte memory
interface bambu_extmem_slave_if #(
  parameter int ADDR_W = 7
);
  logic [1:0]          Mout_oe_ram;
  logic [1:0]          Mout_we_ram;
  logic [2*ADDR_W-1:0] Mout_addr_ram;
  logic [15:0]         Mout_Wdata_ram;
  logic [7:0]          Mout_data_ram_size;
  logic [15:0]         M_Rdata_ram;
  logic [1:0]          M_DataRdy;
  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );
  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/bambu_extmem_slave.sv
// bambu_extmem_slave: two-channel off-chip byte memory model with programmable read/write latency.
// Define EXTMEM_PERF_CNT_EN to add saturating accepted-read/accepted-write counters (rd_count/wr_count).
module bambu_extmem_slave #(
  parameter int ADDR_W      = 7,
  parameter int MEMSIZE     = 32,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  bambu_extmem_slave_if.slave       bus,
  input  logic                      ld_we,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [7:0]                ld_data,
  output logic                      err_both
`ifdef EXTMEM_PERF_CNT_EN
  ,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
`endif
);
  localparam int IW   = MEMSIZE > 1 ? $clog2(MEMSIZE) : 1;
  localparam int MAXD = READ_DELAY > WRITE_DELAY ? READ_DELAY : WRITE_DELAY;
  localparam int CW   = MAXD > 1 ? $clog2(MAXD) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR, DONE} st_t;

  st_t              st_q   [2];
  st_t              st_d   [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [7:0]       hold_q [2];
  logic [7:0]       hold_d [2];
  logic             rd_q   [2];
  logic             rd_d   [2];
  logic             err_q;
  logic             err_set;
  logic [7:0]       mem_q  [MEMSIZE];

  logic [ADDR_W-1:0] addr_c [2];
  logic [31:0]       rel_c  [2];
  logic [IW-1:0]     off_c  [2];
  logic              req_c  [2];
  logic [7:0]        mask_c [2];
  logic [7:0]        wnew_c [2];
  logic [1:0]        acc_rd;
  logic [1:0]        acc_wr;
  logic [31:0]       ld_rel;
  logic [IW-1:0]     ld_off;

  function automatic logic [7:0] wmask(input logic [3:0] s);
    return s >= 4'd8 ? 8'hFF : 8'((9'd1 << s) - 9'd1);
  endfunction

  // decode each channel's request: range check (wrap-around subtract covers addr < BASE_ADDR), acceptance, merged write byte
  always_comb begin
    addr_c  = '{default: '0};
    rel_c   = '{default: '0};
    off_c   = '{default: '0};
    req_c   = '{default: 1'b0};
    mask_c  = '{default: '0};
    wnew_c  = '{default: '0};
    acc_rd  = '0;
    acc_wr  = '0;
    err_set = 1'b0;
    for (int c = 0; c < 2; c++) begin
      addr_c[c] = bus.Mout_addr_ram[c*ADDR_W +: ADDR_W];
      rel_c[c]  = 32'(addr_c[c]) - 32'(BASE_ADDR);
      off_c[c]  = rel_c[c][IW-1:0];
      req_c[c]  = reset && st_q[c] == IDLE && rel_c[c] < 32'(MEMSIZE)
                  && (bus.Mout_oe_ram[c] ^ bus.Mout_we_ram[c]);
      acc_rd[c] = req_c[c] && bus.Mout_oe_ram[c];
      acc_wr[c] = req_c[c] && bus.Mout_we_ram[c];
      mask_c[c] = wmask(bus.Mout_data_ram_size[4*c +: 4]);
      wnew_c[c] = (bus.Mout_Wdata_ram[8*c +: 8] & mask_c[c]) | (mem_q[off_c[c]] & ~mask_c[c]);
      err_set   = err_set || (st_q[c] == IDLE && bus.Mout_oe_ram[c] && bus.Mout_we_ram[c]);
    end
    ld_rel = 32'(ld_addr) - 32'(BASE_ADDR);
    ld_off = ld_rel[IW-1:0];
  end

  // channel FSM next state: load delay-1 on acceptance, count down in BUSY, one DONE cycle, back to IDLE
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    rd_d   = rd_q;
    for (int c = 0; c < 2; c++) begin
      case (st_q[c])
        IDLE: if (acc_rd[c] || acc_wr[c]) begin
          rd_d[c]   = acc_rd[c];
          hold_d[c] = acc_rd[c] ? mem_q[off_c[c]] : hold_q[c];
          cnt_d[c]  = acc_rd[c] ? CW'(READ_DELAY - 1) : CW'(WRITE_DELAY - 1);
          st_d[c]   = cnt_d[c] == '0 ? DONE : acc_rd[c] ? BUSY_RD : BUSY_WR;
        end
        BUSY_RD, BUSY_WR: begin
          cnt_d[c] = cnt_q[c] - CW'(1);
          st_d[c]  = cnt_d[c] == '0 ? DONE : st_q[c];
        end
        default: st_d[c] = IDLE;
      endcase
    end
  end

  // channel state registers; reset drops any pending completion
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q   <= '{IDLE, IDLE};
      cnt_q  <= '{default: '0};
      hold_q <= '{default: '0};
      rd_q   <= '{default: 1'b0};
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      rd_q   <= rd_d;
    end
  end

  // sticky flag for a channel seeing oe and we together while idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  // byte array, never cleared; later writes win: channel 0, then channel 1, then preload
  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++)
      if (acc_wr[c]) mem_q[off_c[c]] <= wnew_c[c];
    if (ld_we && ld_rel < 32'(MEMSIZE)) mem_q[ld_off] <= ld_data;
  end

  // completion pulse and read data only in the DONE cycle, zero otherwise so it can be OR-ed externally
  always_comb begin
    bus.M_DataRdy   = '0;
    bus.M_Rdata_ram = '0;
    for (int c = 0; c < 2; c++) begin
      bus.M_DataRdy[c]         = st_q[c] == DONE;
      bus.M_Rdata_ram[8*c +: 8] = (st_q[c] == DONE && rd_q[c]) ? hold_q[c] : 8'h00;
    end
  end

  assign err_both = err_q;

`ifdef EXTMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [32:0] rd_sum;
  logic [32:0] wr_sum;

  assign rd_sum = {1'b0, rd_cnt_q} + 33'(acc_rd[0]) + 33'(acc_rd[1]);
  assign wr_sum = {1'b0, wr_cnt_q} + 33'(acc_wr[0]) + 33'(acc_wr[1]);

  // accepted-request counters, saturating at all ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_sum[32] ? '1 : rd_sum[31:0];
      wr_cnt_q <= wr_sum[32] ? '1 : wr_sum[31:0];
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_bambu_extmem_slave.sv
// tb_bambu_extmem_slave: random traffic against a cycle-numbered reference model, plus directed latency/conflict/reset cases
module tb_bambu_extmem_slave;
  localparam int AW = 7, MS = 32, BA = 0, RD = 2, WD = 1, RDB = 4, WDB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b1, rst_b = 1'b1;
  logic          ld_we_a = 1'b0, ld_we_b = 1'b0;
  logic [AW-1:0] ld_addr_a = '0, ld_addr_b = '0;
  logic [7:0]    ld_data_a = '0, ld_data_b = '0;
  logic          err_a, err_b;
  int            total = 0, bad = 0;

  bambu_extmem_slave_if #(.ADDR_W(AW)) bus_a ();
  bambu_extmem_slave_if #(.ADDR_W(AW)) bus_b ();

`ifdef EXTMEM_PERF_CNT_EN
  logic [31:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

  bambu_extmem_slave #(.ADDR_W(AW), .MEMSIZE(MS), .BASE_ADDR(BA), .READ_DELAY(RD), .WRITE_DELAY(WD)) dut_a (
    .clock(clk), .reset(rst_a), .bus(bus_a),
    .ld_we(ld_we_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a), .err_both(err_a)
`ifdef EXTMEM_PERF_CNT_EN
    , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
  );

  bambu_extmem_slave #(.ADDR_W(AW), .MEMSIZE(MS), .BASE_ADDR(BA), .READ_DELAY(RDB), .WRITE_DELAY(WDB)) dut_b (
    .clock(clk), .reset(rst_b), .bus(bus_b),
    .ld_we(ld_we_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b), .err_both(err_b)
`ifdef EXTMEM_PERF_CNT_EN
    , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model for dut_a: edges numbered after reset; a request taken at edge e completes in the cycle of edge e+delay-1
  logic [7:0] m_mem  [MS];
  int         m_done [2] = '{-1, -1};
  int         m_free [2] = '{0, 0};
  logic [7:0] m_byte [2] = '{8'h00, 8'h00};
  bit         m_isrd [2] = '{1'b0, 1'b0};
  bit         m_err = 1'b0;
  longint     m_rdc = 0, m_wrc = 0;
  int         edge_n = 0;

  always @(posedge clk or negedge rst_a) begin : model
    bit         oe, we, wok [2];
    int         a, woff [2];
    logic [7:0] msk, wval [2];
    if (!rst_a) begin
      m_done = '{-1, -1};
      m_free = '{0, 0};
      m_err  = 1'b0;
      m_rdc  = 0;
      m_wrc  = 0;
    end else begin
      edge_n++;
      for (int c = 0; c < 2; c++) begin
        oe = bus_a.Mout_oe_ram[c];
        we = bus_a.Mout_we_ram[c];
        a  = int'(bus_a.Mout_addr_ram[c*AW +: AW]) - BA;
        wok[c] = 1'b0;
        if (edge_n >= m_free[c]) begin
          if (oe && we) m_err = 1'b1;
          else if ((oe || we) && a >= 0 && a < MS) begin
            m_isrd[c] = oe;
            m_byte[c] = m_mem[a];
            m_done[c] = edge_n + (oe ? RD : WD) - 1;
            m_free[c] = m_done[c] + 2;
            if (oe) m_rdc++;
            else begin
              m_wrc++;
              msk     = bus_a.Mout_data_ram_size[4*c +: 4] >= 4'd8 ? 8'hFF
                        : 8'((1 << bus_a.Mout_data_ram_size[4*c +: 4]) - 1);
              wok[c]  = 1'b1;
              woff[c] = a;
              wval[c] = (bus_a.Mout_Wdata_ram[8*c +: 8] & msk) | (m_mem[a] & ~msk);
            end
          end
        end
      end
      for (int c = 0; c < 2; c++)
        if (wok[c]) m_mem[woff[c]] = wval[c];
      if (ld_we_a && int'(ld_addr_a) - BA >= 0 && int'(ld_addr_a) - BA < MS) m_mem[int'(ld_addr_a) - BA] = ld_data_a;
    end
  end

  // every cycle: dut_a outputs against the model
  always @(negedge clk) begin : compare
    bit r;
    for (int c = 0; c < 2; c++) begin
      r = (m_done[c] == edge_n);
      chk($sformatf("rdy%0d", c), 32'(bus_a.M_DataRdy[c]), 32'(r));
      chk($sformatf("rdata%0d", c), 32'(bus_a.M_Rdata_ram[8*c +: 8]), (r && m_isrd[c]) ? 32'(m_byte[c]) : 32'd0);
    end
    chk("err", 32'(err_a), 32'(m_err));
`ifdef EXTMEM_PERF_CNT_EN
    chk("rd_count", rdc_a, 32'(m_rdc));
    chk("wr_count", wrc_a, 32'(m_wrc));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_a(input int c, input bit oe, input bit we, input int addr, input logic [7:0] wd, input logic [3:0] sz);
    bus_a.Mout_oe_ram[c]              = oe;
    bus_a.Mout_we_ram[c]              = we;
    bus_a.Mout_addr_ram[c*AW +: AW]   = AW'(addr);
    bus_a.Mout_Wdata_ram[8*c +: 8]    = wd;
    bus_a.Mout_data_ram_size[4*c +: 4] = sz;
  endtask

  task automatic a_wait(input int c, output logic [7:0] d, output int lat);
    lat = 0;
    d   = 8'h00;
    for (int i = 0; i < 20; i++) begin
      cyc();
      lat++;
      if (bus_a.M_DataRdy[c]) begin
        d = bus_a.M_Rdata_ram[8*c +: 8];
        break;
      end
    end
    set_a(c, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    cyc();
  endtask

  task automatic a_read(input int c, input int addr, output logic [7:0] d, output int lat);
    set_a(c, 1'b1, 1'b0, addr, 8'h00, 4'h0);
    a_wait(c, d, lat);
  endtask

  task automatic a_write(input int c, input int addr, input logic [7:0] wd, input logic [3:0] sz, output int lat);
    logic [7:0] d;
    set_a(c, 1'b0, 1'b1, addr, wd, sz);
    a_wait(c, d, lat);
  endtask

  task automatic ld_a(input int addr, input logic [7:0] d);
    ld_we_a = 1'b1; ld_addr_a = AW'(addr); ld_data_a = d;
    cyc();
    ld_we_a = 1'b0;
  endtask

  task automatic b_read(input int addr, output logic [7:0] d, output int lat);
    bus_b.Mout_oe_ram[0] = 1'b1;
    bus_b.Mout_addr_ram[AW-1:0] = AW'(addr);
    lat = 0;
    d   = 8'h00;
    for (int i = 0; i < 20; i++) begin
      cyc();
      lat++;
      if (bus_b.M_DataRdy[0]) begin
        d = bus_b.M_Rdata_ram[7:0];
        break;
      end
    end
    bus_b.Mout_oe_ram[0] = 1'b0;
    cyc();
  endtask

  initial begin
    logic [7:0] d;
    int         lat, seen;
    bit         oe, we, rr;
    int         r;
    bus_a.Mout_oe_ram = '0; bus_a.Mout_we_ram = '0; bus_a.Mout_addr_ram = '0;
    bus_a.Mout_Wdata_ram = '0; bus_a.Mout_data_ram_size = '0;
    bus_b.Mout_oe_ram = '0; bus_b.Mout_we_ram = '0; bus_b.Mout_addr_ram = '0;
    bus_b.Mout_Wdata_ram = '0; bus_b.Mout_data_ram_size = '0;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    cyc(); cyc();
    chk("rst_rdy", 32'(bus_a.M_DataRdy), 0);
    chk("rst_rdata", 32'(bus_a.M_Rdata_ram), 0);
    chk("rst_err", 32'(err_a), 0);
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < MS; i++) ld_a(i, 8'(i * 7 + 3));
    ld_a(5, 8'hA7);
    ld_a(3, 8'hFF);
    // read latency and one-cycle data
    a_read(0, 5, d, lat);
    chk("t1_lat", lat, RD);
    chk("t1_data", d, 8'hA7);
    chk("t1_after", {bus_a.M_DataRdy, bus_a.M_Rdata_ram}, 0);
    // partial write mask
    a_write(1, 3, 8'h00, 4'd4, lat);
    chk("t2_wlat", lat, WD);
    a_read(1, 3, d, lat);
    chk("t2_data", d, 8'hF0);
    chk("t2_model", m_mem[3], 8'hF0);
    // same-byte write conflict: channel 1 wins
    set_a(0, 1'b0, 1'b1, 7, 8'h11, 4'd8);
    set_a(1, 1'b0, 1'b1, 7, 8'h22, 4'd8);
    cyc();
    chk("t3_both_rdy", 32'(bus_a.M_DataRdy), 2'b11);
    set_a(0, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    set_a(1, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    cyc();
    a_read(0, 7, d, lat);
    chk("t3_ww", d, 8'h22);
    // read while other channel writes the same byte: old value
    set_a(0, 1'b1, 1'b0, 9, 8'h00, 4'h0);
    set_a(1, 1'b0, 1'b1, 9, 8'h55, 4'd8);
    cyc();
    chk("t3_wr_rdy", 32'(bus_a.M_DataRdy), 2'b10);
    set_a(1, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    cyc();
    chk("t3_rd_rdy", 32'(bus_a.M_DataRdy), 2'b01);
    chk("t3_rw_old", 32'(bus_a.M_Rdata_ram[7:0]), 8'h42);
    set_a(0, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    cyc();
    a_read(0, 9, d, lat);
    chk("t3_rw_new", d, 8'h55);
    // out of range request is never accepted
    set_a(0, 1'b1, 1'b0, 40, 8'h00, 4'h0);
    seen = 0;
    repeat (10) begin
      cyc();
      seen |= int'(bus_a.M_DataRdy[0]);
    end
    chk("t4_no_rdy", seen, 0);
    chk("t4_no_err", 32'(err_a), 0);
    set_a(0, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    cyc();
    a_read(0, 5, d, lat);
    chk("t4_idle_lat", lat, RD);
    // dut_b: err_both sticky, longer latency, reset mid-read
    ld_we_b = 1'b1; ld_addr_b = AW'(2); ld_data_b = 8'h3C;
    cyc();
    ld_we_b = 1'b0;
    bus_b.Mout_oe_ram[1] = 1'b1; bus_b.Mout_we_ram[1] = 1'b1;
    bus_b.Mout_addr_ram[2*AW-1:AW] = AW'(2);
    cyc();
    bus_b.Mout_oe_ram[1] = 1'b0; bus_b.Mout_we_ram[1] = 1'b0;
    repeat (3) cyc();
    chk("t5_err_sticky", 32'(err_b), 1);
    chk("t5_err_no_rdy", 32'(bus_b.M_DataRdy), 0);
    b_read(2, d, lat);
    chk("t5_lat4", lat, RDB);
    chk("t5_data", d, 8'h3C);
    bus_b.Mout_oe_ram[0] = 1'b1;
    cyc(); cyc();
    rst_b = 1'b0;
    bus_b.Mout_oe_ram[0] = 1'b0;
    #1;
    chk("t5_err_clr", 32'(err_b), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 1) rst_b = 1'b1;
      seen |= int'(bus_b.M_DataRdy[0]);
    end
    chk("t5_dropped", seen, 0);
`ifdef EXTMEM_PERF_CNT_EN
    repeat (3) b_read(2, d, lat);
    bus_b.Mout_we_ram = 2'b11;
    bus_b.Mout_addr_ram = {AW'(11), AW'(10)};
    bus_b.Mout_data_ram_size = 8'h88;
    cyc();
    bus_b.Mout_we_ram = 2'b00;
    repeat (WDB + 1) cyc();
    chk("perf_rd", rdc_b, 3);
    chk("perf_wr", wrc_b, 2);
`endif
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        r  = int'($urandom_range(0, 39));
        oe = r < 14 || r == 39;
        we = (r >= 14 && r < 26) || r == 39;
        set_a(c, oe, we, int'($urandom_range(0, 39)), 8'($urandom), 4'($urandom_range(0, 15)));
      end
      rr        = $urandom_range(0, 149) != 0;
      rst_a     = rr;
      ld_we_a   = rr && $urandom_range(0, 7) == 0;
      ld_addr_a = AW'($urandom_range(0, 39));
      ld_data_a = 8'($urandom);
      cyc();
    end
    rst_a   = 1'b1;
    ld_we_a = 1'b0;
    set_a(0, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    set_a(1, 1'b0, 1'b0, 0, 8'h00, 4'h0);
    repeat (6) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
